// File: rtl/line_mem_ctrl_pkg.sv
// line_mem_ctrl_pkg: types and helpers shared by the cache controller, data array and line memory.
package line_mem_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   localparam int WORD_W = 32;
   localparam int LINE_WORDS = 4;
   typedef logic [LINE_WORDS-1:0][WORD_W-1:0] line_t;
   function automatic logic [31:0] line_index(input logic [63:0] addr, input int line_words, input int depth);
      return 32'((addr >> ($clog2(line_words) + 2)) & 64'(depth - 1));
   endfunction
endpackage

// File: rtl/line_mem_ctrl_if.sv
// line_mem_ctrl_if: request/response bundle between the cache control unit and the line memory.
interface line_mem_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 128
);
   logic              req_valid;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [LINE_W-1:0] req_wdata;
   logic [LINE_W-1:0] rdata;
   logic              ready;
   logic              busy;
   modport master (output req_valid, req_we, req_addr, req_wdata, input rdata, ready, busy);
   modport slave  (input req_valid, req_we, req_addr, req_wdata, output rdata, ready, busy);
endinterface

// File: rtl/line_mem_ctrl_array.sv
// line_mem_ctrl_array: single-port synchronous line-wide storage; only the read register is reset.
module line_mem_ctrl_array #(
   parameter int LINE_W = 128,
   parameter int DEPTH_LINES = 256,
   parameter int IDX_W = $clog2(DEPTH_LINES)
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              i_en,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_idx,
   input  logic [LINE_W-1:0] i_wdata,
   output logic [LINE_W-1:0] o_rdata
);
   logic [LINE_W-1:0] r_mem [DEPTH_LINES];
   logic [LINE_W-1:0] r_rdata;

   always_ff @(posedge clk)
      if (i_en && i_we) r_mem[i_idx] <= i_wdata;

   always_ff @(posedge clk or negedge rst_b)
      if (!rst_b) r_rdata <= '0;
      else if (i_en && !i_we) r_rdata <= r_mem[i_idx];

   assign o_rdata = r_rdata;
endmodule

// File: rtl/line_mem_ctrl.sv
// line_mem_ctrl: fixed-latency line memory serving cache write-backs and refills.
// Requests are captured in IDLE; the storage access happens on the edge that enters DONE.
module line_mem_ctrl #(
   parameter int ADDR_W = 32,
   parameter int LINE_WORDS = line_mem_ctrl_pkg::LINE_WORDS,
   parameter int DEPTH_LINES = 256,
   parameter int LATENCY = 4
) (
   input  logic          clk,
   input  logic          rst_b,
   line_mem_ctrl_if.slave bus
);
   import line_mem_ctrl_pkg::*;

   localparam int LINE_W = WORD_W * LINE_WORDS;
   localparam int IDX_W = $clog2(DEPTH_LINES);
   localparam int CNT_W = $clog2(LATENCY) + 1;

   state_t            r_state, w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [IDX_W-1:0]  r_idx;
   logic              r_we;
   logic [LINE_W-1:0] r_wdata;
   logic              w_accept, w_fire;

   assign w_accept = r_state == IDLE && bus.req_valid;
   assign w_fire = r_state == BUSY && r_cnt == CNT_W'(LATENCY - 1);

   always_comb begin
      w_next = r_state;
      w_next = r_state == IDLE ? (bus.req_valid ? BUSY : IDLE) :
               r_state == BUSY ? (w_fire ? DONE : BUSY) : IDLE;
   end

   always_ff @(posedge clk or negedge rst_b)
      if (!rst_b) begin
         r_state <= IDLE;
         r_cnt <= '0;
      end else begin
         r_state <= w_next;
         r_cnt <= (r_state == BUSY && !w_fire) ? r_cnt + 1'b1 : '0;
      end

   // capture copies decouple the access from inputs that change after acceptance
   always_ff @(posedge clk or negedge rst_b)
      if (!rst_b) begin
         r_idx <= '0;
         r_we <= 1'b0;
         r_wdata <= '0;
      end else if (w_accept) begin
         r_idx <= IDX_W'(line_index(64'(bus.req_addr[ADDR_W-1:0]), LINE_WORDS, DEPTH_LINES));
         r_we <= bus.req_we;
         r_wdata <= bus.req_wdata;
      end

   line_mem_ctrl_array #(
      .LINE_W(LINE_W),
      .DEPTH_LINES(DEPTH_LINES),
      .IDX_W(IDX_W)
   ) u_array (
      .clk(clk),
      .rst_b(rst_b),
      .i_en(w_fire),
      .i_we(r_we),
      .i_idx(r_idx),
      .i_wdata(r_wdata),
      .o_rdata(bus.rdata)
   );

   assign bus.ready = r_state == DONE;
   assign bus.busy = r_state != IDLE;
endmodule
